// File: rtl/vram_arb_pkg.sv
// Shared VRAM arbitration types: read-owner tags, counter width and default bus widths.
// The default ADDR_W/DATA_W are also used by the display fetch unit.
package vram_arb_pkg;

  localparam int unsigned VRAM_ADDR_W = 16;
  localparam int unsigned VRAM_DATA_W = 16;

  // Starvation counter width; covers the full legal BURST_MAX range 1..255.
  localparam int unsigned CNT_W = 8;

  localparam int unsigned OWN_W = 2;

  typedef enum logic [OWN_W-1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CORE = 2'd2
  } own_e;

  // Owner of the read accepted this edge. Writes and idle cycles tag as NONE.
  function automatic own_e read_owner(input logic disp_ack, input logic core_ack,
                                      input logic core_we);
    own_e owner;
    owner = OWN_NONE;
    if (disp_ack) begin
      owner = OWN_DISP;
    end else if (core_ack && !core_we) begin
      owner = OWN_CORE;
    end
    return owner;
  endfunction

endpackage

// File: rtl/vram_arb_grant.sv
// Grant logic for the VRAM arbiter: display priority, optional core starvation guard.
// The guard is built only when VRAM_ARB_STARVE_GUARD_EN is defined.
module vram_arb_grant
  import vram_arb_pkg::*;
#(
  parameter int unsigned BURST_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_disp_req,
  input  logic i_core_req,
  output logic o_disp_ack,
  output logic o_core_ack
);

  logic w_guard;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] r_cnt;

  assign w_guard = (r_cnt == CNT_W'(BURST_MAX));

  // Counts display wins while the core is kept waiting; any core accept or idle core resets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_core_req || o_core_ack) begin
      r_cnt <= '0;
    end else if (o_disp_ack) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  logic w_unused_cfg;

  assign w_guard      = 1'b0;
  assign w_unused_cfg = clk ^ (^BURST_MAX);
`endif

  // Acks are gated by rst_n so nothing is accepted while reset is asserted.
  always_comb begin
    o_disp_ack = rst_n & i_disp_req & ~(i_core_req & w_guard);
    o_core_ack = rst_n & i_core_req & (~i_disp_req | w_guard);
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between core load/store bus and VGA display fetch.
// Optional starvation guard: define VRAM_ARB_STARVE_GUARD_EN.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = VRAM_ADDR_W,
  parameter int unsigned DATA_W    = VRAM_DATA_W,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic              o_disp_ack,
  output logic              o_disp_rvalid,
  output logic [DATA_W-1:0] o_disp_rdata,
  input  logic              i_core_req,
  input  logic              i_core_we,
  input  logic [ADDR_W-1:0] i_core_addr,
  input  logic [DATA_W-1:0] i_core_wdata,
  output logic              o_core_ack,
  output logic              o_core_rvalid,
  output logic [DATA_W-1:0] o_core_rdata,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  logic              w_disp_ack;
  logic              w_core_ack;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  own_e              r_tag1;
  own_e              r_tag2;

  vram_arb_grant #(
    .BURST_MAX (BURST_MAX)
  ) u_grant (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_disp_req (i_disp_req),
    .i_core_req (i_core_req),
    .o_disp_ack (w_disp_ack),
    .o_core_ack (w_core_ack)
  );

  // Command registers plus the 2-stage owner tag pipe. Stage 2 lines up with RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_tag1      <= OWN_NONE;
      r_tag2      <= OWN_NONE;
    end else begin
      r_ram_en <= w_disp_ack | w_core_ack;
      if (w_disp_ack) begin
        r_ram_we    <= 1'b0;
        r_ram_addr  <= i_disp_addr;
        r_ram_wdata <= '0;
      end else if (w_core_ack) begin
        r_ram_we    <= i_core_we;
        r_ram_addr  <= i_core_addr;
        r_ram_wdata <= i_core_we ? i_core_wdata : '0;
      end else begin
        r_ram_we <= 1'b0;
      end
      r_tag1 <= read_owner(w_disp_ack, w_core_ack, i_core_we);
      r_tag2 <= r_tag1;
    end
  end

  always_comb begin
    o_disp_ack    = w_disp_ack;
    o_core_ack    = w_core_ack;
    o_ram_en      = r_ram_en;
    o_ram_we      = r_ram_we;
    o_ram_addr    = r_ram_addr;
    o_ram_wdata   = r_ram_wdata;
    o_disp_rvalid = (r_tag2 == OWN_DISP);
    o_core_rvalid = (r_tag2 == OWN_CORE);
    o_disp_rdata  = i_ram_rdata;
    o_core_rdata  = i_ram_rdata;
  end

endmodule
